// File: rtl/state_dump_engine_if.sv
// Dump beat channel from the snapshot engine to a debug/trace sink.
// The engine drives the beat; the sink answers with out_ready.
interface state_dump_engine_if #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [MEM_AW:0]   out_tag;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/state_dump_engine.sv
// Halts the core and streams the GPRs and/or a data-memory window out
// over a valid/ready channel, registers first, then memory.
module state_dump_engine #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MEM_AW   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [MEM_AW-1:0]   mem_base,
  input  logic [MEM_AW:0]     mem_count,
  output logic                halt_req,
  input  logic                halt_ack,
  output logic [REG_AW-1:0]   reg_raddr,
  input  logic [DATA_W-1:0]   reg_rdata,
  output logic                mem_re,
  output logic [MEM_AW-1:0]   mem_raddr,
  input  logic [DATA_W-1:0]   mem_rdata,
  state_dump_engine_if.master dump,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HALT      = 3'd1;
  localparam logic [2:0] S_REG_RD    = 3'd2;
  localparam logic [2:0] S_MEM_ISSUE = 3'd3;
  localparam logic [2:0] S_MEM_CAP   = 3'd4;
  localparam logic [2:0] S_EMIT      = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  localparam logic [REG_AW-1:0] REG_ONE  = REG_AW'(1);
  localparam logic [REG_AW-1:0] REG_LAST = REG_AW'(NUM_REGS - 1);
  localparam logic [MEM_AW:0]   CNT_ONE  = (MEM_AW+1)'(1);
  localparam logic [MEM_AW:0]   CNT_MAX  = {1'b1, {MEM_AW{1'b0}}};

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [MEM_AW-1:0] base_q;
  logic [MEM_AW:0]   cnt_q;
  logic [MEM_AW:0]   mem_i;
  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;
  logic [MEM_AW:0]   tag_q;

  logic              regs_on;
  logic              mem_on;
  logic              last_reg;
  logic [MEM_AW-1:0] mem_addr_nxt;

  assign regs_on      = mode_q[0];
  assign mem_on       = mode_q[1] && (cnt_q != '0);
  assign last_reg     = (reg_raddr == REG_LAST);
  // mem_i never exceeds the clamped count, so its low bits wrap the address
  assign mem_addr_nxt = base_q + mem_i[MEM_AW-1:0];

  assign dump.out_valid = valid_q;
  assign dump.out_data  = data_q;
  assign dump.out_tag   = tag_q;
  assign dump.out_last  = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      mem_i     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      tag_q     <= '0;
      halt_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_raddr <= '0;
      mem_re    <= 1'b0;
      mem_raddr <= '0;
    end else begin
      done   <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            base_q    <= mem_base;
            cnt_q     <= mem_count[MEM_AW] ? CNT_MAX : mem_count;
            mem_i     <= '0;
            reg_raddr <= '0;
            halt_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_HALT;
          end
        end
        S_HALT: begin
          if (halt_ack) begin
            if (regs_on) begin
              state <= S_REG_RD;
            end else if (mem_on) begin
              mem_re    <= 1'b1;
              mem_raddr <= mem_addr_nxt;
              state     <= S_MEM_ISSUE;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_REG_RD: begin
          data_q  <= reg_rdata;
          tag_q   <= {{(MEM_AW+1-REG_AW){1'b0}}, reg_raddr};
          last_q  <= last_reg && !mem_on;
          valid_q <= 1'b1;
          state   <= S_EMIT;
        end
        S_MEM_ISSUE: begin
          state <= S_MEM_CAP;
        end
        S_MEM_CAP: begin
          data_q  <= mem_rdata;
          tag_q   <= {1'b1, mem_raddr};
          last_q  <= ((mem_i + CNT_ONE) == cnt_q);
          mem_i   <= mem_i + CNT_ONE;
          valid_q <= 1'b1;
          state   <= S_EMIT;
        end
        S_EMIT: begin
          if (dump.out_ready) begin
            valid_q <= 1'b0;
            // last_q already folds in whether a memory section follows the registers
            if (last_q) begin
              state <= S_FINISH;
            end else if (!tag_q[MEM_AW] && !last_reg) begin
              reg_raddr <= reg_raddr + REG_ONE;
              state     <= S_REG_RD;
            end else begin
              mem_re    <= 1'b1;
              mem_raddr <= mem_addr_nxt;
              state     <= S_MEM_ISSUE;
            end
          end
        end
        S_FINISH: begin
          done     <= 1'b1;
          halt_req <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
